// File: rtl/btzk_i2c_pkg.sv
// ---------------------------------------------------------------------------
// btzk_i2c_pkg
// Shared definitions for the btzk_i2c register sequencer:
//   - sequencer state encoding (IDLE, ISSUE, WAIT1, WAIT2, DRAIN, RESP)
//   - register access direction constants RW_WRITE / RW_READ
//   - byte width constant
//   - in_cmd(): true while a command is being run on the bus
// ---------------------------------------------------------------------------
package btzk_i2c_pkg;

  localparam int BYTE_W = 8;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT1 = 3'd2,
    WAIT2 = 3'd3,
    DRAIN = 3'd4,
    RESP  = 3'd5
  } seq_state_t;

  // States in which the master is owned by a command (errors and timeout tracked)
  function automatic logic in_cmd(input seq_state_t st);
    return (st == ISSUE) || (st == WAIT1) || (st == WAIT2) || (st == DRAIN);
  endfunction

endpackage

// File: rtl/btzk_i2c_seq_wdog.sv
// ---------------------------------------------------------------------------
// btzk_i2c_seq_wdog
// Per-command timeout counter for btzk_i2c_seq (only instantiated when
// BTZK_I2C_SEQ_TIMEOUT_EN is defined).
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   clr       clears the count (command accepted)
//   run       count enable (command in progress)
//   expire    high while running with the count at TIMEOUT_CYCLES-1
// ---------------------------------------------------------------------------
module btzk_i2c_seq_wdog
  import btzk_i2c_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int TMO_W          = 21
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expire
);

  localparam logic [TMO_W-1:0] CNT_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] CNT_ZERO = {TMO_W{1'b0}};
  localparam logic [TMO_W-1:0] CNT_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};

  logic [TMO_W-1:0] cnt_r;

  // Expiry lands on the clock edge TIMEOUT_CYCLES after the accept edge
  assign expire = run & (cnt_r == CNT_LAST);

  // Cycle counter: cleared on accept, counts while running, freezes otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= CNT_ZERO;
    end else if (clr) begin
      cnt_r <= CNT_ZERO;
    end else if (run & ~expire) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/btzk_i2c_seq.sv
// ---------------------------------------------------------------------------
// btzk_i2c_seq
// Register-level transaction sequencer in front of the btzk_i2c byte master.
// One register write (dev, reg, data) or register read (dev, reg -> data) per
// command handshake; drives the master's ena/addr/rw/data_wr/busy protocol
// and returns read data plus a sticky error flag per command.
//
// Optional feature: define BTZK_I2C_SEQ_TIMEOUT_EN to abort a command that
// has not completed within TIMEOUT_CYCLES clocks.
//
// Ports:
//   btzk_i2c_seq_clk / btzk_i2c_seq_reset  clock, async active-high reset
//   cmd_valid/cmd_ready                     command handshake
//   cmd_dev_addr[7] cmd_rw cmd_reg_addr[8] cmd_wdata[8]  command fields
//   rsp_valid/rsp_ready                     response handshake
//   rsp_rdata[8] rsp_err                    read byte (0 for writes), error
//   mst_ena mst_addr[7] mst_rw mst_data_wr[8]           to byte master
//   mst_busy mst_data_rd[8] mst_ack_err                 from byte master
// ---------------------------------------------------------------------------
module btzk_i2c_seq
  import btzk_i2c_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int TMO_W          = 21
) (
  input  logic              btzk_i2c_seq_clk,
  input  logic              btzk_i2c_seq_reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [6:0]        cmd_dev_addr,
  input  logic              cmd_rw,
  input  logic [BYTE_W-1:0] cmd_reg_addr,
  input  logic [BYTE_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [BYTE_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mst_ena,
  output logic [6:0]        mst_addr,
  output logic              mst_rw,
  output logic [BYTE_W-1:0] mst_data_wr,
  input  logic              mst_busy,
  input  logic [BYTE_W-1:0] mst_data_rd,
  input  logic              mst_ack_err
);

  // Counter width must cover the timeout value
  if (2**TMO_W <= TIMEOUT_CYCLES) begin : g_tmo_cfg_bad
    $error("btzk_i2c_seq: TMO_W too narrow for TIMEOUT_CYCLES");
  end

  seq_state_t        state_r, state_s;
  logic              busy_q_r;
  logic              cmd_rw_r, cmd_rw_s;
  logic [BYTE_W-1:0] cmd_wdata_r, cmd_wdata_s;
  logic              err_acc_r, err_acc_s;
  logic              cmd_ready_r, cmd_ready_s;
  logic              rsp_valid_r, rsp_valid_s;
  logic [BYTE_W-1:0] rsp_rdata_r, rsp_rdata_s;
  logic              rsp_err_r, rsp_err_s;
  logic              mst_ena_r, mst_ena_s;
  logic [6:0]        mst_addr_r, mst_addr_s;
  logic              mst_rw_r, mst_rw_s;
  logic [BYTE_W-1:0] mst_data_wr_r, mst_data_wr_s;

  logic accept_s, busy_rise_s, busy_fall_s, run_s, expire_s;

  assign accept_s    = cmd_valid & cmd_ready_r;
  assign busy_rise_s = mst_busy & ~busy_q_r;
  assign busy_fall_s = ~mst_busy & busy_q_r;
  assign run_s       = in_cmd(state_r);

`ifdef BTZK_I2C_SEQ_TIMEOUT_EN
  btzk_i2c_seq_wdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TMO_W          (TMO_W)
  ) u_wdog (
    .clk    (btzk_i2c_seq_clk),
    .rst    (btzk_i2c_seq_reset),
    .clr    (accept_s),
    .run    (run_s),
    .expire (expire_s)
  );
`else
  assign expire_s = 1'b0;
`endif

  // Next-state and next-output logic; every output is registered below
  always_comb begin
    state_s       = state_r;
    cmd_rw_s      = cmd_rw_r;
    cmd_wdata_s   = cmd_wdata_r;
    err_acc_s     = err_acc_r | (run_s & mst_ack_err);
    rsp_valid_s   = rsp_valid_r;
    rsp_rdata_s   = rsp_rdata_r;
    rsp_err_s     = rsp_err_r;
    mst_ena_s     = mst_ena_r;
    mst_addr_s    = mst_addr_r;
    mst_rw_s      = mst_rw_r;
    mst_data_wr_s = mst_data_wr_r;

    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s       = ISSUE;
          cmd_rw_s      = cmd_rw;
          cmd_wdata_s   = cmd_wdata;
          err_acc_s     = 1'b0;
          mst_ena_s     = 1'b1;
          mst_addr_s    = cmd_dev_addr;
          mst_rw_s      = RW_WRITE;
          mst_data_wr_s = cmd_reg_addr;
        end else begin
          state_s = IDLE;
        end
      end
      // The first busy rise is the register-address byte being taken; queue
      // the second byte (write data, or a read which forces a repeated start).
      // A rise already visible in ISSUE is honoured so it is never missed.
      ISSUE, WAIT1: begin
        if (busy_rise_s) begin
          state_s = WAIT2;
          if (cmd_rw_r == RW_READ) begin
            mst_rw_s = RW_READ;
          end else begin
            mst_data_wr_s = cmd_wdata_r;
          end
        end else begin
          state_s = WAIT1;
        end
      end
      // Second byte taken: drop ena so the master stops after it
      WAIT2: begin
        if (busy_rise_s) begin
          state_s   = DRAIN;
          mst_ena_s = 1'b0;
        end else begin
          state_s = WAIT2;
        end
      end
      DRAIN: begin
        if (busy_fall_s) begin
          state_s     = RESP;
          rsp_valid_s = 1'b1;
          rsp_rdata_s = (cmd_rw_r == RW_READ) ? mst_data_rd : 8'h00;
          rsp_err_s   = err_acc_r | mst_ack_err;
        end else begin
          state_s = DRAIN;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_s     = IDLE;
          rsp_valid_s = 1'b0;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s     = IDLE;
        mst_ena_s   = 1'b0;
        rsp_valid_s = 1'b0;
      end
    endcase

    // Timeout overrides any bus progress in the same cycle
    if (expire_s) begin
      state_s     = RESP;
      mst_ena_s   = 1'b0;
      rsp_valid_s = 1'b1;
      rsp_err_s   = 1'b1;
      rsp_rdata_s = 8'h00;
    end else begin
      state_s = state_s;
    end

    cmd_ready_s = (state_s == IDLE);
  end

  // State, busy history and all registered outputs
  always_ff @(posedge btzk_i2c_seq_clk or posedge btzk_i2c_seq_reset) begin
    if (btzk_i2c_seq_reset) begin
      state_r       <= IDLE;
      busy_q_r      <= 1'b0;
      cmd_rw_r      <= 1'b0;
      cmd_wdata_r   <= 8'h00;
      err_acc_r     <= 1'b0;
      cmd_ready_r   <= 1'b0;
      rsp_valid_r   <= 1'b0;
      rsp_rdata_r   <= 8'h00;
      rsp_err_r     <= 1'b0;
      mst_ena_r     <= 1'b0;
      mst_addr_r    <= 7'h00;
      mst_rw_r      <= 1'b0;
      mst_data_wr_r <= 8'h00;
    end else begin
      state_r       <= state_s;
      busy_q_r      <= mst_busy;
      cmd_rw_r      <= cmd_rw_s;
      cmd_wdata_r   <= cmd_wdata_s;
      err_acc_r     <= err_acc_s;
      cmd_ready_r   <= cmd_ready_s;
      rsp_valid_r   <= rsp_valid_s;
      rsp_rdata_r   <= rsp_rdata_s;
      rsp_err_r     <= rsp_err_s;
      mst_ena_r     <= mst_ena_s;
      mst_addr_r    <= mst_addr_s;
      mst_rw_r      <= mst_rw_s;
      mst_data_wr_r <= mst_data_wr_s;
    end
  end

  assign cmd_ready   = cmd_ready_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_rdata   = rsp_rdata_r;
  assign rsp_err     = rsp_err_r;
  assign mst_ena     = mst_ena_r;
  assign mst_addr    = mst_addr_r;
  assign mst_rw      = mst_rw_r;
  assign mst_data_wr = mst_data_wr_r;

endmodule
